nibble_frame_collector: RTL and testbench

//  Upstream stage of err_id. Accepts a serial stream of 4-bit words over a valid/ready handshake.

---
 rtl/nibble_frame_collector_pkg.sv | 22 ++
 rtl/nibble_frame_collector_gap_timer.sv | 37 +++
 rtl/nibble_frame_collector.sv | 103 ++++++++++
 tb/tb_nibble_frame_collector.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_frame_collector_pkg.sv
`timescale 1ns/100ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_frame_pkg : shared sizes and state encoding for the collector      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package nibble_frame_pkg;

    localparam int NUM_WORDS = 8;
    localparam int WORD_W    = 4;
    localparam int FRAME_W   = NUM_WORDS * WORD_W;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : nibble_frame_pkg
`default_nettype wire

// File: rtl/nibble_frame_collector_gap_timer.sv
`timescale 1ns/100ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | nfc_gap_timer : idle-gap counter, built only with FRAME_TIMEOUT_EN        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifdef FRAME_TIMEOUT_EN
module nfc_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_count;

    // Fires on the tick that would bring the count up to TIMEOUT_CYC.
    assign expired = tick && (r_count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || expired) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : nfc_gap_timer
`endif
`default_nettype wire

// File: rtl/nibble_frame_collector.sv
`timescale 1ns/100ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_frame_collector : packs 8 nibbles into a held 32-bit frame        |
// | Optional partial-frame timeout: FRAME_TIMEOUT_EN                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nibble_frame_collector
    import nibble_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ack,
    output logic               timeout_err
);

    state_t                            r_state;
    logic [IDX_W-1:0]                  r_idx;
    logic [NUM_WORDS-1:0][WORD_W-1:0]  r_frame;
    logic                              r_frame_valid;
    logic                              r_timeout_err;
    logic                              w_accept;
    logic                              w_expired;

    assign in_ready    = (r_state == FILL) && rst_n;
    assign w_accept    = in_valid && in_ready;
    assign frame_data  = r_frame;
    assign frame_valid = r_frame_valid;
    assign timeout_err = r_timeout_err;

`ifdef FRAME_TIMEOUT_EN
    logic w_tick;
    logic w_clear;

    assign w_tick  = (r_state == FILL) && (r_idx != '0) && !w_accept && !flush;
    assign w_clear = w_accept || (r_idx == '0) || flush;

    nfc_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .tick    (w_tick),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            // Flush overrides everything, including a word offered this cycle.
            if (flush) begin
                r_state       <= FILL;
                r_idx         <= '0;
                r_frame_valid <= 1'b0;
            end else begin
                case (r_state)
                    FILL: begin
                        if (w_accept) begin
                            r_frame[r_idx] <= in_data;
                            if (r_idx == LAST_IDX) begin
                                r_state       <= HOLD;
                                r_frame_valid <= 1'b1;
                                r_idx         <= '0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else if (w_expired) begin
                            r_idx         <= '0;
                            r_timeout_err <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (frame_ack) begin
                            r_state       <= FILL;
                            r_frame_valid <= 1'b0;
                        end
                    end
                    default: r_state <= FILL;
                endcase
            end
        end
    end

endmodule : nibble_frame_collector
`default_nettype wire

// File: tb/tb_nibble_frame_collector.sv
`timescale 1ns/100ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_frame_collector : directed + random scoreboard bench           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_nibble_frame_collector;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ack = 1'b0;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_frame_collector #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of words gathered so far and a "frame held" flag.
    logic [3:0]  m_words[$];
    logic [31:0] exp_frames[$];
    bit          m_hold  = 1'b0;
    bit          m_pulse = 1'b0;
    int          m_gap   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_words.delete();
            m_hold  = 1'b0;
            m_pulse = 1'b0;
            m_gap   = 0;
        end else begin
            m_pulse = 1'b0;
            if (flush) begin
                m_words.delete();
                m_hold = 1'b0;
                m_gap  = 0;
            end else if (m_hold) begin
                if (frame_ack) m_hold = 1'b0;
            end else if (in_valid) begin
                m_words.push_back(in_data);
                m_gap = 0;
                if (m_words.size() == 8) begin
                    logic [31:0] f;
                    f = '0;
                    for (int i = 0; i < 8; i++) f = f | (32'(m_words[i]) << (4 * i));
                    exp_frames.push_back(f);
                    m_words.delete();
                    m_hold = 1'b1;
                end
            end else if (m_words.size() > 0) begin
`ifdef FRAME_TIMEOUT_EN
                m_gap++;
                if (m_gap == TO_CYC) begin
                    m_words.delete();
                    m_gap   = 0;
                    m_pulse = 1'b1;
                end
`endif
            end
        end
    end

    // Monitor: per-cycle handshake checks plus frame scoreboard.
    logic        fv_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_hold));
            check("frame_valid", 32'(frame_valid), 32'(m_hold));
            check("timeout_err", 32'(timeout_err), 32'(m_pulse));
            if (frame_valid && !fv_prev) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    check("frame_data", frame_data, exp_frames.pop_front());
                end
                held = frame_data;
            end else if (frame_valid && fv_prev) begin
                check("frame_stable", frame_data, held);
            end
        end
        fv_prev = frame_valid && rst_n;
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic a, input logic f);
        in_valid  = v;
        in_data   = d;
        frame_ack = a;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t1[8] = '{4'hC, 4'hB, 4'hC, 4'hB, 4'hC, 4'h8, 4'hC, 4'hC};
    logic [3:0] t3[8] = '{4'hD, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC};

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_data", frame_data, 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: continuous stream
        for (int i = 0; i < 8; i++) cyc(1'b1, t1[i], 1'b0, 1'b0);
        check("t1_frame", frame_data, 32'hCC8CBCBC);
        check("t1_valid", 32'(frame_valid), 32'd1);
        check("t1_ready_held", 32'(in_ready), 32'd0);

        // 2: held frame ignores input until acked
        repeat (20) cyc(1'b1, 4'hF, 1'b0, 1'b0);
        check("t2_frozen", frame_data, 32'hCC8CBCBC);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check("t2_ack_valid", 32'(frame_valid), 32'd0);
        check("t2_ack_ready", 32'(in_ready), 32'd1);

        // 3: gappy valid
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, t3[i], 1'b0, 1'b0);
            if (i < 7) cyc(1'b0, 4'h5, 1'b0, 1'b0);
        end
        check("t3_frame", frame_data, 32'hCCCCCCCD);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // 4: flush discards a partial frame and the word offered with it
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'hA, 1'b0, 1'b0);
        check("t4_frame", frame_data, 32'hAAAAAAAA);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'h7, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #0.5;
        check("t5_ready", 32'(in_ready), 32'd0);
        check("t5_valid", 32'(frame_valid), 32'd0);
        check("t5_data", frame_data, 32'h0);
        #0.5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) cyc(1'b1, 4'h9, 1'b0, 1'b0);
        check("t5_not_yet", 32'(frame_valid), 32'd0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        check("t5_frame", frame_data, 32'h99999999);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

`ifdef FRAME_TIMEOUT_EN
        // 6: timeout drops a partial frame; one cycle short does not
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        repeat (TO_CYC) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check("t6_pulse", 32'(timeout_err), 32'd1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'h6, 1'b0, 1'b0);
        check("t6_frame", frame_data, 32'h66666666);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        repeat (TO_CYC - 1) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 3), 1'b0, 1'b0);
        check("t6_no_drop", frame_data, 32'h87654321);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // Random traffic against the model
        repeat (800) begin
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 40) == 0));
        end
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check("leftover_frames", 32'(exp_frames.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_frame_collector
`default_nettype wire
